// File: rtl/decode_issue_buffer.sv
// Decode-to-execute boundary: DEPTH-entry FIFO with valid/ready handshakes,
// a load-use interlock on the head entry, and flush. Define DIB_BYPASS_EN to pass an empty-buffer input straight through.
module decode_issue_buffer #(
    parameter int CTRL_W = 16,
    parameter int DATA_W = 128,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [4:0]        out_rs1,
    output logic [4:0]        out_rs2,
    input  logic              ld_pend_valid,
    input  logic [4:0]        ld_pend_rd,
    output logic [CNT_W-1:0]  count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [CTRL_W-1:0] ctrl_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [4:0]        rs1_q  [DEPTH];
    logic [4:0]        rs2_q  [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              empty_s, full_s, hazard_s, head_valid_s;
    logic              push_s, pop_s, bypass_s;

    // x0 is hardwired to zero, so a pending load to it never blocks.
    function automatic logic rs_hazard(input logic       pend_valid,
                                       input logic [4:0] pend_rd,
                                       input logic [4:0] rs1,
                                       input logic [4:0] rs2);
        return pend_valid & (pend_rd != 5'd0) & ((rs1 == pend_rd) | (rs2 == pend_rd));
    endfunction

    assign empty_s      = (count_q == CNT_W'(0));
    assign full_s       = (count_q == CNT_W'(DEPTH));
    assign hazard_s     = rs_hazard(ld_pend_valid, ld_pend_rd, rs1_q[rd_ptr_q], rs2_q[rd_ptr_q]);
    assign head_valid_s = ~empty_s & ~hazard_s;

`ifdef DIB_BYPASS_EN
    assign bypass_s = empty_s & ~flush & in_valid & out_ready &
                      ~rs_hazard(ld_pend_valid, ld_pend_rd, in_rs1, in_rs2);
`else
    assign bypass_s = 1'b0;
`endif

    assign pop_s    = head_valid_s & out_ready & ~flush;
    assign in_ready = ~full_s | pop_s;
    assign push_s   = in_valid & in_ready & ~flush & ~bypass_s;
    assign count    = count_q;

    // Issue-side outputs: bypassed input, issuable head, or a zeroed bubble.
    always_comb begin
        out_valid = 1'b0;
        out_ctrl  = {CTRL_W{1'b0}};
        out_data  = data_q[rd_ptr_q];
        out_rs1   = 5'd0;
        out_rs2   = 5'd0;
        if (bypass_s) begin
            out_valid = 1'b1;
            out_ctrl  = in_ctrl;
            out_data  = in_data;
            out_rs1   = in_rs1;
            out_rs2   = in_rs2;
        end else if (head_valid_s) begin
            out_valid = 1'b1;
            out_ctrl  = ctrl_q[rd_ptr_q];
            out_rs1   = rs1_q[rd_ptr_q];
            out_rs2   = rs2_q[rd_ptr_q];
        end else begin
            out_valid = 1'b0;
        end
    end

    // Pointer and occupancy next state; flush empties by snapping rd to wr.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = CNT_W'(0);
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= PTR_W'(0);
            rd_ptr_q <= PTR_W'(0);
            count_q  <= CNT_W'(0);
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Control and source-index storage, cleared so bubbles carry no stale control.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                ctrl_q[i] <= {CTRL_W{1'b0}};
                rs1_q[i]  <= 5'd0;
                rs2_q[i]  <= 5'd0;
            end
        end else if (push_s) begin
            ctrl_q[wr_ptr_q] <= in_ctrl;
            rs1_q[wr_ptr_q]  <= in_rs1;
            rs2_q[wr_ptr_q]  <= in_rs2;
        end
    end

    // Data payload storage; never read while its slot is empty, so no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            data_q[wr_ptr_q] <= in_data;
        end
    end

endmodule

// File: tb/tb_decode_issue_buffer.sv
// Scoreboard bench for decode_issue_buffer: accepted inputs queue expectations,
// a monitor pops and compares on each issue; directed checks cover count, stalls, flush and reset.
module tb_decode_issue_buffer;

    localparam int CTRL_W = 16;
    localparam int DATA_W = 128;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 3;

    logic              clk, rst_n, flush;
    logic              in_valid, in_ready, out_valid, out_ready;
    logic [CTRL_W-1:0] in_ctrl, out_ctrl;
    logic [DATA_W-1:0] in_data, out_data;
    logic [4:0]        in_rs1, in_rs2, out_rs1, out_rs2;
    logic              ld_pend_valid;
    logic [4:0]        ld_pend_rd;
    logic [CNT_W-1:0]  count;

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] data;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
    } item_t;

    item_t exp_q[$];
    int    checks = 0;
    int    passes = 0;

    decode_issue_buffer #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .in_rs1(in_rs1), .in_rs2(in_rs2),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
        .out_rs1(out_rs1), .out_rs2(out_rs2),
        .ld_pend_valid(ld_pend_valid), .ld_pend_rd(ld_pend_rd), .count(count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic item_t mk(input int id);
        item_t it;
        it.ctrl = 16'h0100 + 16'(id);
        it.data = {32'(id), 32'hCAFE_0000, 64'(id * 3 + 1)};
        it.rs1  = 5'(id + 7);
        it.rs2  = 5'(id + 11);
        return it;
    endfunction

    function automatic item_t mk_rs(input logic [15:0] c, input logic [4:0] r1, input logic [4:0] r2);
        item_t it;
        it.ctrl = c;
        it.data = {112'h0, c};
        it.rs1  = r1;
        it.rs2  = r2;
        return it;
    endfunction

    task automatic drive(input item_t it);
        in_valid = 1'b1;
        in_ctrl  = it.ctrl;
        in_data  = it.data;
        in_rs1   = it.rs1;
        in_rs2   = it.rs2;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    // Stimulus-side recorder: every accepted input becomes an expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n || flush) exp_q.delete();
            else if (in_valid && in_ready) exp_q.push_back({in_ctrl, in_data, in_rs1, in_rs2});
        end
    end

    // Monitor: each reported issue must match the oldest expectation.
    initial begin
        item_t e;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n && !flush && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_issue: got ctrl %0h, expected no issue", out_ctrl);
                end else begin
                    e = exp_q.pop_front();
                    check("issue_ctrl", 128'(out_ctrl), 128'(e.ctrl));
                    check("issue_data", out_data, e.data);
                    check("issue_rs1", 128'(out_rs1), 128'(e.rs1));
                    check("issue_rs2", 128'(out_rs2), 128'(e.rs2));
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_ctrl = '0; in_data = '0; in_rs1 = '0; in_rs2 = '0;
        ld_pend_valid = 1'b0; ld_pend_rd = 5'd0;

        // Reset state
        tick(); tick(); settle();
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_out_ctrl", 128'(out_ctrl), 128'(0));
        check("rst_out_rs1", 128'(out_rs1), 128'(0));
        check("rst_out_rs2", 128'(out_rs2), 128'(0));
        check("rst_in_ready", 128'(in_ready), 128'(1));
        check("rst_count", 128'(count), 128'(0));
        rst_n = 1'b1;
        tick();

        // Single push, one-cycle latency
        drive(mk_rs(16'h00A5, 5'd1, 5'd2));
        in_data = 128'h11;
        out_ready = 1'b1;
        settle();
`ifdef DIB_BYPASS_EN
        check("t1_bypass_valid", 128'(out_valid), 128'(1));
        check("t1_bypass_ctrl", 128'(out_ctrl), 128'(16'h00A5));
        tick(); idle(); settle();
        check("t1_bypass_count", 128'(count), 128'(0));
`else
        check("t1_lat_valid", 128'(out_valid), 128'(0));
        check("t1_count0", 128'(count), 128'(0));
        tick(); idle(); settle();
        check("t1_count1", 128'(count), 128'(1));
        check("t1_valid", 128'(out_valid), 128'(1));
        check("t1_ctrl", 128'(out_ctrl), 128'(16'h00A5));
`endif
        tick(); settle();
        check("t1_count_end", 128'(count), 128'(0));
        check("t1_valid_end", 128'(out_valid), 128'(0));

        // Fill to DEPTH, fifth waits, then accepted on the first pop
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(mk(i));
            tick();
        end
        drive(mk(4));
        settle();
        check("full_count", 128'(count), 128'(4));
        check("full_in_ready", 128'(in_ready), 128'(0));
        tick();
        out_ready = 1'b1;
        settle();
        check("full_pop_in_ready", 128'(in_ready), 128'(1));
        check("full_pop_count", 128'(count), 128'(4));
        tick(); idle(); settle();
        check("full_swap_count", 128'(count), 128'(4));
        repeat (4) tick();
        settle();
        check("full_drain_count", 128'(count), 128'(0));

        // Load-use hazard on rs1 for two cycles
        ld_pend_valid = 1'b1; ld_pend_rd = 5'd5;
        drive(mk_rs(16'h0333, 5'd5, 5'd6));
        tick(); idle(); settle();
        check("haz_c1_valid", 128'(out_valid), 128'(0));
        check("haz_c1_ctrl", 128'(out_ctrl), 128'(0));
        check("haz_c1_count", 128'(count), 128'(1));
        tick(); settle();
        check("haz_c2_valid", 128'(out_valid), 128'(0));
        check("haz_c2_ctrl", 128'(out_ctrl), 128'(0));
        tick();
        ld_pend_valid = 1'b0;
        settle();
        check("haz_release_valid", 128'(out_valid), 128'(1));
        check("haz_release_ctrl", 128'(out_ctrl), 128'(16'h0333));
        tick(); settle();
        check("haz_count_end", 128'(count), 128'(0));

        // Hazard via rs2
        ld_pend_valid = 1'b1; ld_pend_rd = 5'd12;
        drive(mk_rs(16'h0355, 5'd9, 5'd12));
        tick(); idle(); settle();
        check("haz_rs2_valid", 128'(out_valid), 128'(0));
        tick();
        ld_pend_valid = 1'b0;
        settle();
        check("haz_rs2_release", 128'(out_valid), 128'(1));
        tick();

        // Pending load to x0 never stalls
        ld_pend_valid = 1'b1; ld_pend_rd = 5'd0;
        out_ready = 1'b0;
        drive(mk_rs(16'h0444, 5'd0, 5'd0));
        tick(); idle();
        out_ready = 1'b1;
        settle();
        check("x0_valid", 128'(out_valid), 128'(1));
        check("x0_ctrl", 128'(out_ctrl), 128'(16'h0444));
        tick();
        ld_pend_valid = 1'b0;
        settle();
        check("x0_count_end", 128'(count), 128'(0));

        // Flush with three held entries and a same-cycle input
        out_ready = 1'b0;
        for (int i = 10; i < 13; i++) begin
            drive(mk(i));
            tick();
        end
        drive(mk(13));
        flush = 1'b1;
        settle();
        check("flush_pre_count", 128'(count), 128'(3));
        check("flush_in_ready", 128'(in_ready), 128'(1));
        tick();
        flush = 1'b0;
        idle();
        settle();
        check("flush_count", 128'(count), 128'(0));
        check("flush_valid", 128'(out_valid), 128'(0));
        out_ready = 1'b1;
        repeat (3) tick();
        settle();
        check("flush_stays_empty", 128'(out_valid), 128'(0));

        // Full-throughput stream wraps pointers
        for (int i = 20; i < 30; i++) begin
            drive(mk(i));
            tick();
        end
        idle();
        settle();
`ifdef DIB_BYPASS_EN
        check("wrap_count", 128'(count), 128'(0));
`else
        check("wrap_count", 128'(count), 128'(1));
`endif
        tick(); settle();
        check("wrap_count_end", 128'(count), 128'(0));

`ifdef DIB_BYPASS_EN
        // Same-cycle bypass on an empty buffer
        drive(mk_rs(16'h0042, 5'd3, 5'd4));
        settle();
        check("byp_valid", 128'(out_valid), 128'(1));
        check("byp_ctrl", 128'(out_ctrl), 128'(16'h0042));
        check("byp_count", 128'(count), 128'(0));
        tick(); idle(); settle();
        check("byp_count_after", 128'(count), 128'(0));
`endif

        // Reset mid-operation drops everything
        out_ready = 1'b0;
        drive(mk(40));
        tick();
        drive(mk(41));
        tick();
        idle();
        rst_n = 1'b0;
        #1;
        check("midrst_count", 128'(count), 128'(0));
        check("midrst_valid", 128'(out_valid), 128'(0));
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (2) tick();
        settle();
        check("midrst_stays_empty", 128'(out_valid), 128'(0));

        check("scoreboard_drained", 128'(exp_q.size()), 128'(0));
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
